// File: rtl/dram_mux_emu.sv
// Multiplexed-address DRAM emulation, fully synchronous to i_MCLK with edge-detected strobes.
// Define DRAM_MUX_CBR_REFRESH_EN to enable CAS-before-RAS refresh tracking (CBR_ARMED/REFRESH).
module dram_mux_emu #(
  parameter int DW        = 4,
  parameter int ROW_AW    = 8,
  parameter int COL_AW    = 6,
  parameter int MUX_AW    = 8,
  parameter int COL_LSB   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic              i_MCLK,
  input  logic              i_RST,
  input  logic [MUX_AW-1:0] i_ADDR,
  input  logic [DW-1:0]     i_DIN,
  input  logic              i_RAS_n,
  input  logic              i_CAS_n,
  input  logic              i_WE_n,
  input  logic              i_OE_n,
  output logic [DW-1:0]     o_DOUT,
  output logic              o_DVALID,
  output logic              o_PROTO_ERR,
  output logic [ROW_AW-1:0] o_REF_CNT,
  output logic [2:0]        o_STATE
);

  localparam int AW = ROW_AW + COL_AW;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ROW_OPEN   = 3'd1,
    COL_ACTIVE = 3'd2,
    CBR_ARMED  = 3'd3,
    REFRESH    = 3'd4
  } state_t;

  logic [DW-1:0]     mem [2**AW];
  state_t            state_q;
  logic              ras_q, cas_q, we_q;
  logic [ROW_AW-1:0] row_q;
  logic [COL_AW-1:0] col_q;
  logic              rd_pend_q;
  logic [DW-1:0]     dout_q;
  logic              dvalid_q, perr_q;

  logic              ras_fall, ras_rise, cas_fall, cas_rise, we_fall;
  logic              early_wr, late_wr, wr_en, rd_fire;
  logic [ROW_AW-1:0] row_in;
  logic [COL_AW-1:0] col_in;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic              unused_addr;

  assign ras_fall = ras_q & ~i_RAS_n;
  assign ras_rise = ~ras_q & i_RAS_n;
  assign cas_fall = cas_q & ~i_CAS_n;
  assign cas_rise = ~cas_q & i_CAS_n;
  assign we_fall  = we_q & ~i_WE_n;

  assign row_in      = i_ADDR[ROW_AW-1:0];
  assign col_in      = i_ADDR[COL_LSB +: COL_AW];
  assign unused_addr = ^i_ADDR;

  // RAS rising always wins over a write detected on the same edge; reset cancels both kinds.
  assign early_wr = (state_q == ROW_OPEN) & ~ras_rise & cas_fall & ~i_WE_n & ~i_RST;
  assign late_wr  = (state_q == COL_ACTIVE) & ~ras_rise & we_fall & ~i_RST;
  assign wr_en    = early_wr | late_wr;
  assign wr_addr  = early_wr ? {col_in, row_q} : {col_q, row_q};
  assign rd_addr  = {col_q, row_q};
  assign rd_fire  = rd_pend_q & ~i_OE_n & i_WE_n;

  always_ff @(posedge i_MCLK) begin
    if (wr_en) begin
      mem[wr_addr] <= i_DIN;
    end
  end

`ifdef DRAM_MUX_CBR_REFRESH_EN
  logic [ROW_AW-1:0] ref_q;
  assign o_REF_CNT = ref_q;
`else
  assign o_REF_CNT = '0;
`endif

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      ras_q     <= 1'b1;
      cas_q     <= 1'b1;
      we_q      <= 1'b1;
      row_q     <= '0;
      col_q     <= '0;
      rd_pend_q <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      perr_q    <= 1'b0;
`ifdef DRAM_MUX_CBR_REFRESH_EN
      ref_q     <= '0;
`endif
    end else begin
      ras_q     <= i_RAS_n;
      cas_q     <= i_CAS_n;
      we_q      <= i_WE_n;
      dvalid_q  <= 1'b0;
      perr_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      // A read scheduled at the column latch completes even if RAS closes the row now.
      if (rd_fire) begin
        dout_q   <= mem[rd_addr];
        dvalid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (ras_fall) begin
            state_q <= ROW_OPEN;
            row_q   <= row_in;
            perr_q  <= ~i_CAS_n;
          end
`ifdef DRAM_MUX_CBR_REFRESH_EN
          else if (cas_fall) begin
            state_q <= CBR_ARMED;
          end
`endif
        end
        ROW_OPEN: begin
          if (ras_rise) begin
            state_q <= IDLE;
          end else if (cas_fall) begin
            state_q   <= COL_ACTIVE;
            col_q     <= col_in;
            rd_pend_q <= i_WE_n;
          end
        end
        COL_ACTIVE: begin
          if (ras_rise) begin
            state_q <= IDLE;
          end else if (cas_rise) begin
            state_q <= ROW_OPEN;
          end
        end
`ifdef DRAM_MUX_CBR_REFRESH_EN
        CBR_ARMED: begin
          if (ras_fall) begin
            state_q <= REFRESH;
            ref_q   <= ref_q + 1'b1;
          end else if (cas_rise) begin
            state_q <= IDLE;
          end
        end
        REFRESH: begin
          if (ras_rise) begin
            state_q <= i_CAS_n ? IDLE : CBR_ARMED;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_DOUT      = dout_q;
  assign o_DVALID    = dvalid_q;
  assign o_PROTO_ERR = perr_q;
  assign o_STATE     = state_q;

endmodule

// File: tb/tb_dram_mux_emu.sv
// Directed bench for dram_mux_emu with default geometry (row = ADDR[7:0], col = ADDR[6:1]).
module tb_dram_mux_emu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [3:0] din;
  logic       ras_n, cas_n, we_n, oe_n;
  logic [3:0] dout;
  logic       dvalid, perr;
  logic [7:0] ref_cnt;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dram_mux_emu dut (
    .i_MCLK      (clk),
    .i_RST       (rst),
    .i_ADDR      (addr),
    .i_DIN       (din),
    .i_RAS_n     (ras_n),
    .i_CAS_n     (cas_n),
    .i_WE_n      (we_n),
    .i_OE_n      (oe_n),
    .o_DOUT      (dout),
    .o_DVALID    (dvalid),
    .o_PROTO_ERR (perr),
    .o_REF_CNT   (ref_cnt),
    .o_STATE     (state)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge that consumed them.
  task automatic cyc(input logic r, input logic c, input logic w, input logic o,
                     input logic [7:0] a, input logic [3:0] d);
    ras_n = r; cas_n = c; we_n = w; oe_n = o; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input string tag, input logic [7:0] row, input logic [7:0] ca,
                           input logic [3:0] exp);
    cyc(0, 1, 1, 1, row, 4'h0);
    cyc(0, 0, 1, 0, ca, 4'h0);
    check({tag, "_lat0"}, 16'(dvalid), 16'd0);
    cyc(0, 0, 1, 0, ca, 4'h0);
    check({tag, "_dv"}, 16'(dvalid), 16'd1);
    check({tag, "_dout"}, 16'(dout), 16'(exp));
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    check({tag, "_pulse"}, 16'(dvalid), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    rst = 1'b0;
    check("rst_state", 16'(state), 16'd0);
    check("rst_dout", 16'(dout), 16'd0);
    check("rst_dvalid", 16'(dvalid), 16'd0);
    check("rst_perr", 16'(perr), 16'd0);
    check("rst_refcnt", 16'(ref_cnt), 16'd0);

    // Early write 0x9 to row 0x5A col 6, then read it back.
    cyc(0, 1, 1, 1, 8'h5A, 4'h0);
    check("ew_row_open", 16'(state), 16'd1);
    cyc(0, 0, 0, 1, 8'h0C, 4'h9);
    check("ew_col_active", 16'(state), 16'd2);
    cyc(0, 0, 0, 1, 8'h0C, 4'h9);
    check("ew_no_read", 16'(dvalid), 16'd0);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    check("ew_idle", 16'(state), 16'd0);
    read_word("rd9", 8'h5A, 8'h0C, 4'h9);

    // Page-mode early writes of 1..4 into cols 0..3 of row 0x11.
    cyc(0, 1, 1, 1, 8'h11, 4'h0);
    for (int c = 0; c < 4; c++) begin
      cyc(0, 0, 0, 1, 8'(c << 1), 4'(c + 1));
      cyc(0, 0, 0, 1, 8'(c << 1), 4'(c + 1));
      cyc(0, 1, 1, 1, 8'(c << 1), 4'h0);
    end
    check("pg_row_held", 16'(state), 16'd1);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);

    // Second page reads cols 3..0, expecting 4,3,2,1.
    cyc(0, 1, 1, 1, 8'h11, 4'h0);
    for (int c = 3; c >= 0; c--) begin
      cyc(0, 0, 1, 0, 8'(c << 1), 4'h0);
      cyc(0, 0, 1, 0, 8'(c << 1), 4'h0);
      check($sformatf("pg_dv_c%0d", c), 16'(dvalid), 16'd1);
      check($sformatf("pg_dout_c%0d", c), 16'(dout), 16'(c + 1));
      cyc(0, 1, 1, 1, 8'h00, 4'h0);
      check($sformatf("pg_state_c%0d", c), 16'(state), 16'd1);
    end
    cyc(1, 1, 1, 1, 8'h00, 4'h0);

    // RAS rise on the same edge as a late-write WE fall: write is dropped.
    cyc(0, 1, 1, 1, 8'h11, 4'h0);
    cyc(0, 0, 1, 1, 8'h00, 4'h0);
    cyc(1, 0, 0, 1, 8'h00, 4'h7);
    check("abort_idle", 16'(state), 16'd0);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    read_word("abort_rd", 8'h11, 8'h00, 4'h1);

    // Read-modify-write on row 0x5A col 6.
    cyc(0, 1, 1, 1, 8'h5A, 4'h0);
    cyc(0, 0, 1, 0, 8'h0C, 4'h0);
    cyc(0, 0, 1, 0, 8'h0C, 4'h0);
    check("rmw_rd_dv", 16'(dvalid), 16'd1);
    check("rmw_rd_dout", 16'(dout), 16'h9);
    cyc(0, 0, 0, 1, 8'h0C, 4'h3);
    check("rmw_wr_nodv", 16'(dvalid), 16'd0);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    read_word("rmw_rerd", 8'h5A, 8'h0C, 4'h3);

    // RAS and CAS falling together.
    cyc(0, 0, 1, 1, 8'h5A, 4'h0);
    check("pe_pulse", 16'(perr), 16'd1);
    check("pe_state", 16'(state), 16'd1);
    cyc(0, 0, 1, 1, 8'h5A, 4'h0);
    check("pe_one_cycle", 16'(perr), 16'd0);
    check("pe_cas_ignored", 16'(state), 16'd1);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);

`ifdef DRAM_MUX_CBR_REFRESH_EN
    // One hidden refresh, then 299 plain CBR cycles: 300 total, wraps to 44.
    cyc(1, 0, 1, 1, 8'h00, 4'h0);
    check("cbr_armed", 16'(state), 16'd3);
    cyc(0, 0, 1, 1, 8'h00, 4'h0);
    check("cbr_refresh", 16'(state), 16'd4);
    check("cbr_cnt1", 16'(ref_cnt), 16'd1);
    cyc(1, 0, 1, 1, 8'h00, 4'h0);
    check("cbr_hidden", 16'(state), 16'd3);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    check("cbr_exit", 16'(state), 16'd0);
    for (int i = 0; i < 299; i++) begin
      cyc(1, 0, 1, 1, 8'h00, 4'h0);
      cyc(0, 0, 1, 1, 8'h00, 4'h0);
      cyc(1, 1, 1, 1, 8'h00, 4'h0);
    end
    check("cbr_cnt300", 16'(ref_cnt), 16'd44);
    check("cbr_idle", 16'(state), 16'd0);
`else
    // Without refresh support, a CAS fall in IDLE is ignored.
    cyc(1, 0, 1, 1, 8'h00, 4'h0);
    check("nocbr_idle", 16'(state), 16'd0);
    cyc(0, 0, 1, 1, 8'h5A, 4'h0);
    check("nocbr_row", 16'(state), 16'd1);
    check("nocbr_perr", 16'(perr), 16'd1);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    check("nocbr_refcnt", 16'(ref_cnt), 16'd0);
`endif
    read_word("keep_5a", 8'h5A, 8'h0C, 4'h3);
    read_word("keep_11", 8'h11, 8'h04, 4'h3);

    // Reset in COL_ACTIVE on the same edge as a WE fall.
    cyc(0, 1, 1, 1, 8'h5A, 4'h0);
    cyc(0, 0, 1, 1, 8'h0C, 4'h0);
    check("rst_pre_state", 16'(state), 16'd2);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 8'h0C, 4'hF);
    rst = 1'b0;
    check("rstm_state", 16'(state), 16'd0);
    check("rstm_dout", 16'(dout), 16'd0);
    check("rstm_dvalid", 16'(dvalid), 16'd0);
    check("rstm_perr", 16'(perr), 16'd0);
    check("rstm_refcnt", 16'(ref_cnt), 16'd0);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    cyc(1, 1, 1, 1, 8'h00, 4'h0);
    read_word("rstm_keep", 8'h5A, 8'h0C, 4'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
